state_sequence_checker: RTL

- Receive-side companion to the 4-state cycling sequencer (a->b->c->d->a, encoded 0->1->2->3->0).
- Samples a 2-bit state stream and confirms it follows the legal cyclic order.
- Declares lock after a run of legal transitions, then flags every illegal transition, counts errors and counts full cycles (3->0 wraps).
- Sits beside the sequencer in testbenches and at subsystem boundaries that consume its state output.

---
 rtl/state_sequence_checker_if.sv | 32 +++
 rtl/state_sequence_checker.sv | 113 +++++++++++
 2 files changed

// File: rtl/state_sequence_checker_if.sv
// Purpose: bundles the sampled state stream and the checker's status outputs.
// Latency: none; this is wiring only.
// Backpressure: none; in_valid qualifies each sample and the checker never stalls it.
// Signals:
//   in_valid, state_in                 - observed stream, driven by the master
//   locked, error, expected, fsm_state - checker status, driven by the slave
//   error_count (ERR_W), wrap_count (WRAP_W)
interface state_sequence_checker_if #(
  parameter int ERR_W  = 8,
  parameter int WRAP_W = 16
);
  logic              in_valid;
  logic [1:0]        state_in;
  logic              locked;
  logic              error;
  logic [1:0]        expected;
  logic [ERR_W-1:0]  error_count;
  logic [WRAP_W-1:0] wrap_count;
  logic [1:0]        fsm_state;

  // master: whoever presents the stream (sequencer side or a bench)
  modport master (
    output in_valid, state_in,
    input  locked, error, expected, error_count, wrap_count, fsm_state
  );

  // slave: the checker
  modport slave (
    input  in_valid, state_in,
    output locked, error, expected, error_count, wrap_count, fsm_state
  );
endinterface

// File: rtl/state_sequence_checker.sv
// Purpose: verifies a 2-bit state stream follows 0->1->2->3->0, locks, flags and counts slips.
// Latency: every output is registered and reflects the sample taken on the previous edge.
// Backpressure: none; samples are taken whenever in_valid is high, nothing is held back.
// Ports: clock, reset (synchronous, active-high), bus (state_sequence_checker_if.slave).
// Optional: define STATE_CHECK_STICKY_EN to make the first slip while locked latch into
//   FAULT until reset, instead of falling back to ACQUIRE.
module state_sequence_checker #(
  parameter int LOCK_COUNT = 3,
  parameter int ERR_W      = 8,
  parameter int WRAP_W     = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  state_sequence_checker_if.slave bus
);

  // run must be able to reach LOCK_COUNT
  localparam int RUN_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } state_t;

  state_t            state;
  logic [1:0]        last;
  logic [RUN_W-1:0]  run;
  logic              locked_q;
  logic              error_q;
  logic [1:0]        expected_q;
  logic [ERR_W-1:0]  err_cnt;
  logic [WRAP_W-1:0] wrap_cnt;

  logic [1:0] next_legal;
  logic       legal;
  logic       is_wrap;

  assign next_legal = last + 2'd1;
  // a repeated value never equals last+1, so it is illegal by construction
  assign legal      = (bus.state_in == next_legal);
  assign is_wrap    = (last == 2'd3) && (bus.state_in == 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 2'd0;
      run        <= '0;
      locked_q   <= 1'b0;
      error_q    <= 1'b0;
      // expected tracks last+1, so with last=0 it reads 1 out of reset
      expected_q <= 2'd1;
      err_cnt    <= '0;
      wrap_cnt   <= '0;
    end else begin
      error_q <= 1'b0;
      // FAULT swallows every sample, including the expected update
      if (bus.in_valid && (state != FAULT)) begin
        last       <= bus.state_in;
        expected_q <= bus.state_in + 2'd1;
        case (state)
          IDLE: begin
            run   <= '0;
            state <= ACQUIRE;
          end
          ACQUIRE: begin
            if (legal) begin
              run <= run + RUN_W'(1);
              if (run == RUN_W'(LOCK_COUNT - 1)) begin
                state    <= LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              // slips while acquiring only restart the run; they are not errors
              run <= '0;
            end
          end
          LOCKED: begin
            if (legal) begin
              if (is_wrap) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
              end
            end else begin
              error_q  <= 1'b1;
              locked_q <= 1'b0;
              run      <= '0;
              if (err_cnt != {ERR_W{1'b1}}) begin
                err_cnt <= err_cnt + ERR_W'(1);
              end
`ifdef STATE_CHECK_STICKY_EN
              state <= FAULT;
`else
              state <= ACQUIRE;
`endif
            end
          end
          default: begin
            state <= state;
          end
        endcase
      end
    end
  end

  assign bus.locked      = locked_q;
  assign bus.error       = error_q;
  assign bus.expected    = expected_q;
  assign bus.error_count = err_cnt;
  assign bus.wrap_count  = wrap_cnt;
  assign bus.fsm_state   = state;

endmodule
